ro_buffer_param: RTL and testbench
==================================

RO_BUFFER_PARAM -- requirements
Module: ro_buffer_param

Interface
REQ-001 SHALL have parameters: DEPTH, default 16, entry count (power of two, >=4); WB_PORTS, default 3, writeback channels; TAG_W, default $clog2(DEPTH), tag width.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  reset; rdy  in  1  low pauses block.
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 SHALL have ports: alloc_valid in 1; alloc_dest in 5 (rd); alloc_type in 3 (ALU, LOAD, STORE, BRANCH, JAL, JALR); alloc_ready out 1 (=!full); alloc_tag out TAG_W (current tail).
REQ-005 SHALL have ports: wb_valid in WB_PORTS; wb_tag in WB_PORTS*TAG_W; wb_value in WB_PORTS*32; wb_redirect in WB_PORTS (mispredict flag); wb_target in WB_PORTS*32 (correct PC).
REQ-006 SHALL have ports: flush_in in 1, external flush.
REQ-007 SHALL have outputs: cmt_reg_valid 1, cmt_reg_rd 5, cmt_reg_value 32, cmt_store_valid 1, cmt_tag TAG_W, redirect_valid 1, redirect_pc 32, head_tag TAG_W, full 1, empty 1.

Function
REQ-008 SHALL hold DEPTH entries in a circular buffer; pointers carry one extra wrap bit; all DEPTH slots usable, including slot 0.
REQ-009 SHALL compute full = (indices equal, wrap bits differ) and empty = (pointers equal), combinationally from registered pointers.
REQ-010 SHALL accept an allocation when alloc_valid && alloc_ready: entry written with dest and type, ready cleared, redirect cleared, tail advanced by 1 modulo DEPTH.
REQ-011 SHALL NOT raise alloc_ready in a full cycle even if a commit occurs in that cycle.
REQ-012 SHALL, per writeback port with wb_valid set, mark entry wb_tag ready and store value, redirect and target; the lowest port index wins on a duplicate tag; writes to unallocated entries are ignored.
REQ-013 SHALL commit at most one entry per cycle: the head entry, when it is non-empty and ready; earliest commit is the edge after the writeback edge.
REQ-014 SHALL, on commit, drive registered one-cycle pulses: ALU/LOAD/JAL/JALR set cmt_reg_valid with rd and value, suppressed when rd=0; STORE sets cmt_store_valid; cmt_tag = committed index.
REQ-015 SHALL, on commit of a BRANCH/JAL/JALR entry with redirect set, pulse redirect_valid with redirect_pc = target; the register write of that entry is issued in the same cycle (single-phase, no second commit pass).
REQ-016 SHALL, on a redirect commit or flush_in, reset head and tail to 0 (wrap bits 0) at that edge; same-cycle allocations and writebacks are discarded.
REQ-017 SHALL, when flush_in coincides with a commit, perform the commit outputs and then flush.
REQ-018 SHALL, while rdy=0, freeze all state and force every pulse output (cmt_reg_valid, cmt_store_valid, redirect_valid) to 0.

Reset
REQ-019 SHALL, on rst, clear head, tail, all entry ready bits and all pulse outputs to 0; cmt_reg_rd, cmt_reg_value, redirect_pc and cmt_tag reset to 0; empty=1, full=0 afterwards.
REQ-020 SHALL give rst priority over rdy and flush_in.

Configuration
REQ-021 SHALL, with ROB_OCCUPANCY_EN defined, add output occupancy ($clog2(DEPTH)+1 bits) = tail-head with wrap bits, registered and updated on the same edge as the pointers; without the macro, the port and its logic are absent.

Structure
REQ-022 SHALL take the entry-type encodings (ALU..JALR) and the default DEPTH from the shared def package; the entry record is a local struct.
REQ-023 SHALL implement the writeback arbitration across ports as sub-module rob_wb_merge (per-entry priority select).

Verification
REQ-024 Reset, then 16 allocs with no commits -> full=1 on edge 16, alloc_ready=0, alloc_tag=0 after wrap.
REQ-025 Alloc ALU rd=5; wb value 0x1234 on port 2 -> cmt_reg_valid, rd=5, value=0x1234 one edge later; empty=1.
REQ-026 Alloc 3 entries; writeback tags 2,1,0 in that order -> commits occur in order 0,1,2 on consecutive cycles.
REQ-027 Alloc JALR rd=1, then 2 ALU; JALR wb value 0x104, redirect=1, target 0x200 -> reg write x1=0x104 and redirect_pc=0x200 in the same cycle; head=tail=0 next.
REQ-028 rdy=0 for 3 cycles with a ready head -> no pulses; commit occurs on the first rdy=1 edge.
REQ-029 Ports 0 and 1 write the same tag, values 0xA and 0xB -> committed value 0xA.

Source files
------------

// File: rtl/ro_buffer_param_pkg.sv
// Shared definitions for the reorder buffer: entry-type encodings, default depth
// and small decode helpers for commit behaviour.
package ro_buffer_param_pkg;

    localparam int ROB_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        ET_ALU    = 3'd0,
        ET_LOAD   = 3'd1,
        ET_STORE  = 3'd2,
        ET_BRANCH = 3'd3,
        ET_JAL    = 3'd4,
        ET_JALR   = 3'd5
    } entry_type_e;

    function automatic logic writes_rd(input logic [2:0] t);
        return (t == ET_ALU) || (t == ET_LOAD) || (t == ET_JAL) || (t == ET_JALR);
    endfunction

    // Only control-flow entries may carry a redirect; the flag is ignored elsewhere.
    function automatic logic is_ctrl(input logic [2:0] t);
        return (t == ET_BRANCH) || (t == ET_JAL) || (t == ET_JALR);
    endfunction

endpackage

// File: rtl/ro_buffer_param_wb_merge.sv
// Writeback merge for a single ROB entry: picks the lowest-index port whose tag
// matches this entry.
module rob_wb_merge #(
    parameter int WB_PORTS = 3,
    parameter int TAG_W    = 4,
    parameter int IDX      = 0
) (
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]    wb_value,
    input  logic [WB_PORTS-1:0]       wb_redirect,
    input  logic [WB_PORTS*32-1:0]    wb_target,
    output logic                      hit,
    output logic [31:0]               value,
    output logic                      redirect,
    output logic [31:0]               target
);

    always_comb begin
        hit      = 1'b0;
        value    = '0;
        redirect = 1'b0;
        target   = '0;
        // Scan from the top so the lowest matching port is the last to write.
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == TAG_W'(IDX))) begin
                hit      = 1'b1;
                value    = wb_value[p*32 +: 32];
                redirect = wb_redirect[p];
                target   = wb_target[p*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/ro_buffer_param.sv
// Reorder buffer: DEPTH-entry circular queue, multi-port writeback, in-order single commit.
// Define ROB_OCCUPANCY_EN to add a registered occupancy output.
module ro_buffer_param
    import ro_buffer_param_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH_DEF,
    parameter int WB_PORTS = 3,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      alloc_valid,
    input  logic [4:0]                alloc_dest,
    input  logic [2:0]                alloc_type,
    output logic                      alloc_ready,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]    wb_value,
    input  logic [WB_PORTS-1:0]       wb_redirect,
    input  logic [WB_PORTS*32-1:0]    wb_target,
    input  logic                      flush_in,
`ifdef ROB_OCCUPANCY_EN
    output logic [$clog2(DEPTH):0]    occupancy,
`endif
    output logic                      cmt_reg_valid,
    output logic [4:0]                cmt_reg_rd,
    output logic [31:0]               cmt_reg_value,
    output logic                      cmt_store_valid,
    output logic [TAG_W-1:0]          cmt_tag,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc,
    output logic [TAG_W-1:0]          head_tag,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = TAG_W + 1;

    typedef struct packed {
        logic [4:0]  dest;
        logic [2:0]  etype;
        logic        ready;
        logic        redirect;
        logic [31:0] value;
        logic [31:0] target;
    } rob_entry_t;

    rob_entry_t ents_q [DEPTH];
    rob_entry_t ents_d [DEPTH];
    rob_entry_t head_e;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count;
    logic [TAG_W-1:0] head_idx, tail_idx;
    logic             commit, redir, kill;

    logic             cmt_reg_valid_q, cmt_reg_valid_d;
    logic [4:0]       cmt_reg_rd_q, cmt_reg_rd_d;
    logic [31:0]      cmt_reg_value_q, cmt_reg_value_d;
    logic             cmt_store_valid_q, cmt_store_valid_d;
    logic [TAG_W-1:0] cmt_tag_q, cmt_tag_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;

    logic [DEPTH-1:0]       wb_hit, wb_redir, in_use;
    logic [DEPTH-1:0][31:0] wb_val, wb_tgt;

    assign head_idx    = head_q[TAG_W-1:0];
    assign tail_idx    = tail_q[TAG_W-1:0];
    assign count       = tail_q - head_q;
    assign full        = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign empty       = (head_q == tail_q);
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign head_tag    = head_idx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [TAG_W-1:0] off;
        // An entry is live when its distance from head is below the occupancy.
        assign off       = TAG_W'(i) - head_idx;
        assign in_use[i] = {1'b0, off} < count;

        rob_wb_merge #(.WB_PORTS(WB_PORTS), .TAG_W(TAG_W), .IDX(i)) u_merge (
            .wb_valid    (wb_valid),
            .wb_tag      (wb_tag),
            .wb_value    (wb_value),
            .wb_redirect (wb_redirect),
            .wb_target   (wb_target),
            .hit         (wb_hit[i]),
            .value       (wb_val[i]),
            .redirect    (wb_redir[i]),
            .target      (wb_tgt[i])
        );
    end

    always_comb begin
        head_d            = head_q;
        tail_d            = tail_q;
        ents_d            = ents_q;
        cmt_reg_valid_d   = 1'b0;
        cmt_store_valid_d = 1'b0;
        redirect_valid_d  = 1'b0;
        cmt_reg_rd_d      = cmt_reg_rd_q;
        cmt_reg_value_d   = cmt_reg_value_q;
        cmt_tag_d         = cmt_tag_q;
        redirect_pc_d     = redirect_pc_q;
        head_e            = ents_q[head_idx];
        commit            = rdy && !empty && head_e.ready;
        redir             = commit && head_e.redirect && is_ctrl(head_e.etype);
        kill              = redir || (rdy && flush_in);

        if (commit) begin
            head_d            = head_q + 1'b1;
            cmt_tag_d         = head_idx;
            cmt_store_valid_d = (head_e.etype == ET_STORE);
            if (writes_rd(head_e.etype) && (head_e.dest != 5'd0)) begin
                cmt_reg_valid_d = 1'b1;
                cmt_reg_rd_d    = head_e.dest;
                cmt_reg_value_d = head_e.value;
            end
            if (redir) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = head_e.target;
            end
        end

        if (rdy && !kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_hit[i] && in_use[i]) begin
                    ents_d[i].ready    = 1'b1;
                    ents_d[i].value    = wb_val[i];
                    ents_d[i].redirect = wb_redir[i];
                    ents_d[i].target   = wb_tgt[i];
                end
            end
            if (alloc_valid && alloc_ready) begin
                ents_d[tail_idx].dest     = alloc_dest;
                ents_d[tail_idx].etype    = alloc_type;
                ents_d[tail_idx].ready    = 1'b0;
                ents_d[tail_idx].redirect = 1'b0;
                tail_d                    = tail_q + 1'b1;
            end
        end

        // Redirect or external flush restarts the queue; the commit above still reports.
        if (kill) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q            <= '0;
            tail_q            <= '0;
            for (int i = 0; i < DEPTH; i++) ents_q[i] <= '0;
            cmt_reg_valid_q   <= 1'b0;
            cmt_reg_rd_q      <= '0;
            cmt_reg_value_q   <= '0;
            cmt_store_valid_q <= 1'b0;
            cmt_tag_q         <= '0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= '0;
        end else begin
            head_q            <= head_d;
            tail_q            <= tail_d;
            ents_q            <= ents_d;
            cmt_reg_valid_q   <= cmt_reg_valid_d;
            cmt_reg_rd_q      <= cmt_reg_rd_d;
            cmt_reg_value_q   <= cmt_reg_value_d;
            cmt_store_valid_q <= cmt_store_valid_d;
            cmt_tag_q         <= cmt_tag_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_pc_q     <= redirect_pc_d;
        end
    end

    assign cmt_reg_valid   = cmt_reg_valid_q;
    assign cmt_reg_rd      = cmt_reg_rd_q;
    assign cmt_reg_value   = cmt_reg_value_q;
    assign cmt_store_valid = cmt_store_valid_q;
    assign cmt_tag         = cmt_tag_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;

`ifdef ROB_OCCUPANCY_EN
    localparam int OCC_W = $clog2(DEPTH) + 1;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    assign occupancy_d = OCC_W'(tail_d - head_d);
    always_ff @(posedge clk) begin
        if (rst) occupancy_q <= '0;
        else     occupancy_q <= occupancy_d;
    end
    assign occupancy = occupancy_q;
`endif

endmodule

// File: tb/tb_ro_buffer_param.sv
// Self-checking bench for ro_buffer_param: directed scenarios plus random traffic
// against a queue-level reference model, with a scoreboard-driven commit monitor.
module tb_ro_buffer_param;

    localparam int DEPTH = 16;
    localparam int WB    = 3;
    localparam int TW    = 4;
    localparam int ALU = 0, LOAD = 1, STORE = 2, BRANCH = 3, JAL = 4, JALR = 5;

    logic            clk = 1'b0;
    logic            rst, rdy, alloc_valid, alloc_ready, flush_in;
    logic [4:0]      alloc_dest;
    logic [2:0]      alloc_type;
    logic [TW-1:0]   alloc_tag, cmt_tag, head_tag;
    logic [WB-1:0]   wb_valid, wb_redirect;
    logic [WB*TW-1:0] wb_tag;
    logic [WB*32-1:0] wb_value, wb_target;
    logic            cmt_reg_valid, cmt_store_valid, redirect_valid, full, empty;
    logic [4:0]      cmt_reg_rd;
    logic [31:0]     cmt_reg_value, redirect_pc;
`ifdef ROB_OCCUPANCY_EN
    logic [TW:0]     occupancy;
`endif

    always #5 clk = ~clk;

    ro_buffer_param #(.DEPTH(DEPTH), .WB_PORTS(WB), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_type(alloc_type),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_redirect(wb_redirect), .wb_target(wb_target), .flush_in(flush_in),
`ifdef ROB_OCCUPANCY_EN
        .occupancy(occupancy),
`endif
        .cmt_reg_valid(cmt_reg_valid), .cmt_reg_rd(cmt_reg_rd), .cmt_reg_value(cmt_reg_value),
        .cmt_store_valid(cmt_store_valid), .cmt_tag(cmt_tag),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .head_tag(head_tag), .full(full), .empty(empty)
    );

    typedef struct {
        int        cyc;
        bit        reg_v;
        bit [4:0]  rd;
        bit [31:0] val;
        bit        st_v;
        bit [3:0]  tag;
        bit        rd_v;
        bit [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: live entries are head .. head+count-1 modulo DEPTH.
    int        m_head, m_count;
    bit [4:0]  m_dest [DEPTH];
    int        m_type [DEPTH];
    bit        m_rdy  [DEPTH];
    bit        m_red  [DEPTH];
    bit [31:0] m_val  [DEPTH];
    bit [31:0] m_tgt  [DEPTH];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_head = 0;
        m_count = 0;
        for (int i = 0; i < DEPTH; i++) m_rdy[i] = 0;
    endtask

    task automatic model_step();
        int h0, c0, t, tg, s;
        bit commit, kill, regw, st, rv;
        bit [DEPTH-1:0] claimed;
        exp_t e;
        if (!rdy) return;
        h0 = m_head;
        c0 = m_count;
        commit = (c0 > 0) && m_rdy[h0];
        rv = 0;
        if (commit) begin
            t    = m_type[h0];
            regw = (t == ALU || t == LOAD || t == JAL || t == JALR) && (m_dest[h0] != 0);
            st   = (t == STORE);
            rv   = (t == BRANCH || t == JAL || t == JALR) && m_red[h0];
            if (regw || st || rv) begin
                e.cyc = cyc + 1; e.reg_v = regw; e.rd = m_dest[h0]; e.val = m_val[h0];
                e.st_v = st; e.tag = 4'(h0); e.rd_v = rv; e.pc = m_tgt[h0];
                exp_q.push_back(e);
            end
        end
        kill = rv || flush_in;
        if (kill) begin
            m_head = 0;
            m_count = 0;
        end else begin
            claimed = '0;
            for (int p = 0; p < WB; p++) begin
                if (wb_valid[p]) begin
                    tg = int'(wb_tag[p*TW +: TW]);
                    if (!claimed[tg] && ((tg - h0 + DEPTH) % DEPTH) < c0) begin
                        m_rdy[tg] = 1;
                        m_val[tg] = wb_value[p*32 +: 32];
                        m_red[tg] = wb_redirect[p];
                        m_tgt[tg] = wb_target[p*32 +: 32];
                    end
                    claimed[tg] = 1;
                end
            end
            if (alloc_valid && c0 < DEPTH) begin
                s = (h0 + c0) % DEPTH;
                m_dest[s] = alloc_dest; m_type[s] = int'(alloc_type);
                m_rdy[s] = 0; m_red[s] = 0;
                m_count++;
            end
            if (commit) begin
                m_head = (m_head + 1) % DEPTH;
                m_count--;
            end
        end
    endtask

    task automatic check_state();
        chk("full", full, m_count == DEPTH);
        chk("empty", empty, m_count == 0);
        chk("alloc_ready", alloc_ready, m_count < DEPTH);
        chk("alloc_tag", alloc_tag, (m_head + m_count) % DEPTH);
        chk("head_tag", head_tag, m_head);
`ifdef ROB_OCCUPANCY_EN
        chk("occupancy", occupancy, m_count);
`endif
    endtask

    task automatic clear_inputs();
        alloc_valid = 0; alloc_dest = 0; alloc_type = 0; flush_in = 0;
        wb_valid = '0; wb_tag = '0; wb_value = '0; wb_redirect = '0; wb_target = '0;
    endtask

    // Inputs are set at a negedge; compare state, advance the model, move to the next negedge.
    task automatic tick();
        check_state();
        model_step();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic set_alloc(input int dest, input int typ);
        alloc_valid = 1; alloc_dest = 5'(dest); alloc_type = 3'(typ);
    endtask

    task automatic set_wb(input int p, input int tag, input logic [31:0] v,
                          input logic r, input logic [31:0] t);
        wb_valid[p] = 1'b1;
        wb_tag[p*TW +: TW] = TW'(tag);
        wb_value[p*32 +: 32] = v;
        wb_redirect[p] = r;
        wb_target[p*32 +: 32] = t;
    endtask

    function automatic int next_tag();
        return (m_head + m_count) % DEPTH;
    endfunction

    exp_t mon_e;
    bit   mon_ok;
    always @(negedge clk) begin
        if (!rst && (cmt_reg_valid || cmt_store_valid || redirect_valid)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected cyc=%0d tag=%0d reg=%b st=%b redir=%b",
                         cyc, cmt_tag, cmt_reg_valid, cmt_store_valid, redirect_valid);
            end else begin
                mon_e = exp_q.pop_front();
                mon_ok = (mon_e.cyc == cyc) && (cmt_reg_valid == mon_e.reg_v) &&
                         (cmt_store_valid == mon_e.st_v) && (redirect_valid == mon_e.rd_v) &&
                         (cmt_tag == mon_e.tag) &&
                         (!mon_e.reg_v || (cmt_reg_rd == mon_e.rd && cmt_reg_value == mon_e.val)) &&
                         (!mon_e.rd_v || redirect_pc == mon_e.pc);
                if (!mon_ok) begin
                    errors++;
                    $display("FAIL commit actual cyc=%0d reg=%b rd=%0d val=%h st=%b tag=%0d redir=%b pc=%h expected cyc=%0d reg=%b rd=%0d val=%h st=%b tag=%0d redir=%b pc=%h",
                             cyc, cmt_reg_valid, cmt_reg_rd, cmt_reg_value, cmt_store_valid, cmt_tag,
                             redirect_valid, redirect_pc, mon_e.cyc, mon_e.reg_v, mon_e.rd, mon_e.val,
                             mon_e.st_v, mon_e.tag, mon_e.rd_v, mon_e.pc);
                end
            end
        end
    end

    int t0, t1, t2;

    initial begin
        clear_inputs();
        rst = 1; rdy = 0; flush_in = 1;
        repeat (3) @(negedge clk);
        // Reset has priority over a low rdy and an asserted flush.
        chk("rst_cmt_reg_valid", cmt_reg_valid, 0);
        chk("rst_cmt_store_valid", cmt_store_valid, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_cmt_reg_rd", cmt_reg_rd, 0);
        chk("rst_cmt_reg_value", cmt_reg_value, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_cmt_tag", cmt_tag, 0);
        rst = 0; rdy = 1; clear_inputs();
        model_reset();

        // Fill all 16 slots, then try one more while full.
        for (int i = 0; i < DEPTH; i++) begin set_alloc(i + 1, ALU); tick(); end
        chk("fill_full", full, 1);
        chk("fill_alloc_tag_wrap", alloc_tag, 0);
        set_alloc(3, ALU); tick();
        flush_in = 1; tick();

        // Single ALU op written back on port 2.
        t0 = next_tag(); set_alloc(5, ALU); tick();
        set_wb(2, t0, 32'h1234, 0, 0); tick();
        repeat (2) tick();

        // Out-of-order writeback, in-order commit.
        t0 = next_tag(); set_alloc(1, ALU); tick();
        t1 = next_tag(); set_alloc(2, LOAD); tick();
        t2 = next_tag(); set_alloc(3, STORE); tick();
        set_wb(0, t2, 32'h22, 0, 0); tick();
        set_wb(0, t1, 32'h11, 0, 0); tick();
        set_wb(0, t0, 32'h00, 0, 0); tick();
        repeat (4) tick();

        // Mispredicted JALR: register write and redirect together, then queue restarts.
        t0 = next_tag(); set_alloc(1, JALR); tick();
        t1 = next_tag(); set_alloc(2, ALU); tick();
        set_alloc(3, ALU); set_wb(1, t1, 32'h55, 0, 0); tick();
        set_wb(0, t0, 32'h104, 1, 32'h200); tick();
        repeat (3) tick();

        // Stall with a ready head.
        t0 = next_tag(); set_alloc(7, ALU); tick();
        set_wb(0, t0, 32'h77, 0, 0); tick();
        rdy = 0; set_alloc(8, ALU); repeat (3) tick();
        rdy = 1; repeat (2) tick();

        // Duplicate tag on ports 0 and 1.
        t0 = next_tag(); set_alloc(9, ALU); tick();
        set_wb(0, t0, 32'hA, 0, 0); set_wb(1, t0, 32'hB, 0, 0); tick();
        repeat (2) tick();

        // Flush coinciding with a commit, plus a same-cycle allocation that is dropped.
        t0 = next_tag(); set_alloc(4, ALU); tick();
        set_wb(0, t0, 32'h44, 0, 0); tick();
        flush_in = 1; set_alloc(6, ALU); tick();
        repeat (2) tick();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            rdy = ($urandom % 8) != 0;
            if ($urandom % 10 < 6) set_alloc($urandom % 8, $urandom % 6);
            for (int p = 0; p < WB; p++) begin
                if ($urandom % 10 < 4) begin
                    if (m_count > 0 && $urandom % 10 != 0)
                        set_wb(p, (m_head + int'($urandom % m_count)) % DEPTH, $urandom,
                               ($urandom % 4) == 0, $urandom);
                    else
                        set_wb(p, $urandom % DEPTH, $urandom, ($urandom % 4) == 0, $urandom);
                end
            end
            flush_in = ($urandom % 40) == 0;
            tick();
        end

        // Drain whatever is left.
        rdy = 1;
        for (int k = 0; k < 200 && m_count > 0; k++) begin
            if (!m_rdy[m_head]) set_wb(0, m_head, $urandom, 0, 0);
            tick();
        end
        repeat (3) tick();
        chk("drain_empty", empty, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
